// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_pkg
// Description : Shared types for the RV32 decode stage. This file holds the
//               operation enum, the opcode constants, the immediate-format enum,
//               the decoded-entry struct and the immediate generator.
//               The M-extension enum values are always reserved here. The
//               RV32M_DECODE_EN macro only controls whether decode_comb
//               produces them.
// Revision    : 1.0 - initial release
// ============================================================================
package decode_pkg;

  localparam int OP_ENUM_W = 6;

  typedef enum logic [OP_ENUM_W-1:0] {
    OP_NOP, OP_ILLEGAL,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
    OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
    OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;

  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_fmt_e;

  typedef struct packed {
    op_e         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;      // 32-bit sign-extended; widened to XLEN by the stage
    logic        rd_we;
    logic        illegal;
  } decoded_t;

  localparam decoded_t c_dec_nop = '{op: OP_NOP, rd: 5'd0, rs1: 5'd0, rs2: 5'd0,
                                      imm: 32'd0, rd_we: 1'b0, illegal: 1'b0};

  // Build the 32-bit sign-extended immediate from instruction bits [31:7]
  function automatic logic [31:0] imm_gen(input logic [31:7] ib, input imm_fmt_e fmt);
    logic [31:0] r;
    r = 32'd0;
    case (fmt)
      IMM_I:   r = {{20{ib[31]}}, ib[31:20]};
      IMM_S:   r = {{20{ib[31]}}, ib[31:25], ib[11:7]};
      IMM_B:   r = {{19{ib[31]}}, ib[31], ib[7], ib[30:25], ib[11:8], 1'b0};
      IMM_U:   r = {ib[31:12], 12'd0};
      IMM_J:   r = {{11{ib[31]}}, ib[31], ib[19:12], ib[20], ib[30:21], 1'b0};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_comb.sv
`default_nettype none
// ============================================================================
// Module      : decode_comb
// Description : Purely combinational RV32I decoder that maps a raw
//               instruction to a decoded_t entry. The decoder flags illegal
//               encodings and gates rd_we.
//               Define RV32M_DECODE_EN to also decode the M-extension ops.
//               When it is undefined, those encodings are reported as illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_comb
  import decode_pkg::*;
(
  input  logic [31:0] i_instr,
  output decoded_t    o_dec
);

  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic [4:0] w_rd;
  op_e        w_op;
  imm_fmt_e   w_fmt;
  logic       w_wr;
  logic       w_ill;

  assign w_opc = i_instr[6:0];
  assign w_f3  = i_instr[14:12];
  assign w_f7  = i_instr[31:25];
  assign w_rd  = i_instr[11:7];

  // Opcode/funct3/funct7 -> operation, immediate format and rd-write intent
  always_comb begin
    w_op  = OP_ILLEGAL;
    w_fmt = IMM_NONE;
    w_wr  = 1'b0;
    case (w_opc)
      OPC_LUI:   begin w_op = OP_LUI;   w_fmt = IMM_U; w_wr = 1'b1; end
      OPC_AUIPC: begin w_op = OP_AUIPC; w_fmt = IMM_U; w_wr = 1'b1; end
      OPC_JAL:   begin w_op = OP_JAL;   w_fmt = IMM_J; w_wr = 1'b1; end
      OPC_JALR: begin
        if (w_f3 == 3'b000) begin w_op = OP_JALR; w_fmt = IMM_I; w_wr = 1'b1; end
      end
      OPC_BRANCH: begin
        w_fmt = IMM_B;
        case (w_f3)
          3'b000:  w_op = OP_BEQ;
          3'b001:  w_op = OP_BNE;
          3'b100:  w_op = OP_BLT;
          3'b101:  w_op = OP_BGE;
          3'b110:  w_op = OP_BLTU;
          3'b111:  w_op = OP_BGEU;
          default: w_op = OP_ILLEGAL;
        endcase
      end
      OPC_LOAD: begin
        w_fmt = IMM_I;
        w_wr  = 1'b1;
        case (w_f3)
          3'b000:  w_op = OP_LB;
          3'b001:  w_op = OP_LH;
          3'b010:  w_op = OP_LW;
          3'b100:  w_op = OP_LBU;
          3'b101:  w_op = OP_LHU;
          default: w_op = OP_ILLEGAL;
        endcase
      end
      OPC_STORE: begin
        w_fmt = IMM_S;
        case (w_f3)
          3'b000:  w_op = OP_SB;
          3'b001:  w_op = OP_SH;
          3'b010:  w_op = OP_SW;
          default: w_op = OP_ILLEGAL;
        endcase
      end
      OPC_OPIMM: begin
        w_fmt = IMM_I;
        w_wr  = 1'b1;
        case (w_f3)
          3'b000: w_op = OP_ADDI;
          3'b010: w_op = OP_SLTI;
          3'b011: w_op = OP_SLTIU;
          3'b100: w_op = OP_XORI;
          3'b110: w_op = OP_ORI;
          3'b111: w_op = OP_ANDI;
          // RV32 shifts: shamt[5] (instr[25]) must be zero, funct7 fully checked
          3'b001: w_op = (w_f7 == 7'b0000000) ? OP_SLLI : OP_ILLEGAL;
          3'b101: begin
            if (w_f7 == 7'b0000000)      w_op = OP_SRLI;
            else if (w_f7 == 7'b0100000) w_op = OP_SRAI;
            else                         w_op = OP_ILLEGAL;
          end
          default: w_op = OP_ILLEGAL;
        endcase
      end
      OPC_OP: begin
        w_wr = 1'b1;
        if (w_f7 == 7'b0000000) begin
          case (w_f3)
            3'b000: w_op = OP_ADD;
            3'b001: w_op = OP_SLL;
            3'b010: w_op = OP_SLT;
            3'b011: w_op = OP_SLTU;
            3'b100: w_op = OP_XOR;
            3'b101: w_op = OP_SRL;
            3'b110: w_op = OP_OR;
            3'b111: w_op = OP_AND;
            default: w_op = OP_ILLEGAL;
          endcase
        end else if (w_f7 == 7'b0100000) begin
          if (w_f3 == 3'b000)      w_op = OP_SUB;
          else if (w_f3 == 3'b101) w_op = OP_SRA;
          else                     w_op = OP_ILLEGAL;
        end
`ifdef RV32M_DECODE_EN
        else if (w_f7 == 7'b0000001) begin
          case (w_f3)
            3'b000: w_op = OP_MUL;
            3'b001: w_op = OP_MULH;
            3'b010: w_op = OP_MULHSU;
            3'b011: w_op = OP_MULHU;
            3'b100: w_op = OP_DIV;
            3'b101: w_op = OP_DIVU;
            3'b110: w_op = OP_REM;
            3'b111: w_op = OP_REMU;
            default: w_op = OP_ILLEGAL;
          endcase
        end
`endif
      end
      OPC_MISCMEM: begin
        // FENCE has no architectural effect in this pipeline
        if (w_f3 == 3'b000) w_op = OP_NOP;
      end
      default: w_op = OP_ILLEGAL;
    endcase
    // Compressed / non-32-bit encodings are not supported
    if (i_instr[1:0] != 2'b11) w_op = OP_ILLEGAL;
  end

  assign w_ill = (w_op == OP_ILLEGAL);

  // Assemble the decoded entry; illegal entries carry no immediate and never write
  always_comb begin
    o_dec         = c_dec_nop;
    o_dec.op      = w_op;
    o_dec.rd      = w_rd;
    o_dec.rs1     = i_instr[19:15];
    o_dec.rs2     = i_instr[24:20];
    o_dec.imm     = w_ill ? 32'd0 : imm_gen(i_instr[31:7], w_fmt);
    o_dec.rd_we   = w_wr && !w_ill && (w_rd != 5'd0);
    o_dec.illegal = w_ill;
  end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Registered RV32 decode stage with a valid/ready handshake and
//               a 2-entry skid buffer (main = output register, skid = spare).
//               The in_ready signal is registered and equals !skid_valid.
//               A flush kills all entries.
//               Optional macro RV32M_DECODE_EN (in decode_comb) enables the
//               decoding of M-extension ops.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OP_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] out_op,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic            out_rd_we,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
);

  decoded_t        w_dec;
  decoded_t        r_main;
  decoded_t        r_skid;
  logic [XLEN-1:0] r_main_pc;
  logic [XLEN-1:0] r_skid_pc;
  logic            r_main_v;
  logic            r_skid_v;
  logic            r_in_ready;
  logic            w_acc;
  logic            w_main_free;
  logic            w_skid_load;
  logic            w_skid_v_nxt;

  decode_comb u_decode_comb (
    .i_instr (in_instr),
    .o_dec   (w_dec)
  );

  assign w_acc       = in_valid && r_in_ready;
  // Main can take a new entry this edge if empty or being consumed
  assign w_main_free = !r_main_v || out_ready;
  // An accept that cannot go to main parks in the skid register
  assign w_skid_load = w_acc && !w_main_free;

  // Next skid occupancy, which also determines next in_ready
  always_comb begin
    w_skid_v_nxt = r_skid_v;
    if (w_skid_load)      w_skid_v_nxt = 1'b1;
    else if (w_main_free) w_skid_v_nxt = 1'b0;
  end

  // Main/skid registers: skid refills main first to keep FIFO order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main     <= c_dec_nop;
      r_skid     <= c_dec_nop;
      r_main_pc  <= '0;
      r_skid_pc  <= '0;
      r_main_v   <= 1'b0;
      r_skid_v   <= 1'b0;
      r_in_ready <= 1'b1;
    end else if (flush) begin
      r_main_v   <= 1'b0;
      r_skid_v   <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_main_free) begin
        if (r_skid_v) begin
          r_main    <= r_skid;
          r_main_pc <= r_skid_pc;
          r_main_v  <= 1'b1;
          r_skid    <= c_dec_nop;
          r_skid_pc <= '0;
        end else if (w_acc) begin
          r_main    <= w_dec;
          r_main_pc <= in_pc;
          r_main_v  <= 1'b1;
        end else begin
          r_main_v  <= 1'b0;
        end
      end
      if (w_skid_load) begin
        r_skid    <= w_dec;
        r_skid_pc <= in_pc;
      end
      r_skid_v   <= w_skid_v_nxt;
      r_in_ready <= !w_skid_v_nxt;
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_main_v;
  assign out_op      = OP_W'(r_main.op);
  assign out_rd      = r_main.rd;
  assign out_rs1     = r_main.rs1;
  assign out_rs2     = r_main.rs2;
  assign out_rd_we   = r_main.rd_we;
  assign out_illegal = r_main.illegal;
  assign out_pc      = r_main_pc;

  generate
    if (XLEN > 32) begin : g_imm_wide
      assign out_imm = {{(XLEN-32){r_main.imm[31]}}, r_main.imm};
    end else begin : g_imm_narrow
      assign out_imm = r_main.imm;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Scoreboard bench for decode_stage. The driver queues the
//               expected entries. A monitor compares each entry that the
//               stage hands downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;
  import decode_pkg::*;

  typedef struct {
    op_e         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        we;
    logic        ill;
    logic [31:0] pc;
    bit          full;   // compare register fields and immediate too
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_imm, out_pc;
  logic [5:0]  out_op;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic        out_rd_we, out_illegal;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  decode_stage #(.XLEN(32), .OP_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_rd_we(out_rd_we), .out_illegal(out_illegal), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(op_e op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                              logic [31:0] imm, logic we, logic [31:0] pc);
    exp_t e;
    e.op = op; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
    e.we = we; e.ill = 1'b0; e.pc = pc; e.full = 1'b1;
    return e;
  endfunction

  function automatic exp_t mk_ill(logic [31:0] pc);
    exp_t e;
    e.op = OP_ILLEGAL; e.rd = 0; e.rs1 = 0; e.rs2 = 0; e.imm = 0;
    e.we = 1'b0; e.ill = 1'b1; e.pc = pc; e.full = 1'b0;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offer one instruction; the expectation is queued only once the handshake is certain
  task automatic send(input logic [31:0] instr, input exp_t e);
    int guard;
    in_valid = 1'b1; in_instr = instr; in_pc = e.pc;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    n_chk++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready stuck at %b for pc %h, required 1", in_ready, e.pc);
    end else begin
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Monitor: pop and compare on every downstream handshake; also check hold stability
  initial begin
    bit          stalled;
    logic [63:0] held;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (stalled && out_valid) begin
        n_chk++;
        if ({out_op, out_rd, out_imm, out_pc[20:0]} !== held) begin
          n_fail++;
          $display("FAIL hold_stable: got op=%0d imm=%h pc=%h, changed while stalled", out_op, out_imm, out_pc);
        end
      end
      stalled = rst_n && out_valid && !out_ready;
      held    = {out_op, out_rd, out_imm, out_pc[20:0]};
      if (rst_n && out_valid && out_ready) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got pc=%h op=%0d, required no output", out_pc, out_op);
        end else begin
          exp_t e;
          bit ok;
          e  = sb.pop_front();
          ok = (op_e'(out_op) == e.op) && (out_rd_we === e.we) &&
               (out_illegal === e.ill) && (out_pc === e.pc);
          if (e.full)
            ok = ok && (out_rd === e.rd) && (out_rs1 === e.rs1) &&
                 (out_rs2 === e.rs2) && (out_imm === e.imm);
          if (!ok) begin
            n_fail++;
            $display("FAIL entry pc=%h: got op=%0d rd=%0d rs1=%0d rs2=%0d imm=%h we=%b ill=%b pc=%h; required op=%0d rd=%0d rs1=%0d rs2=%0d imm=%h we=%b ill=%b",
                     e.pc, out_op, out_rd, out_rs1, out_rs2, out_imm, out_rd_we, out_illegal, out_pc,
                     e.op, e.rd, e.rs1, e.rs2, e.imm, e.we, e.ill);
          end
        end
      end
    end
  end

  initial begin
    exp_t div_e;
    int   guard;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0;
    #12;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_in_ready",  {31'd0, in_ready},  32'd1);
    check("reset_out_op",    {26'd0, out_op},    {26'd0, OP_NOP});
    check("reset_out_imm",   out_imm,            32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic decode, latency 1
    send(32'h002081B3, mk(OP_ADD, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1, 32'h100));
    check("latency_add", {31'd0, out_valid}, 32'd1);
    send(32'hFFF00093, mk(OP_ADDI, 5'd1, 5'd0, 5'd31, 32'hFFFFFFFF, 1'b1, 32'h104));
    send(32'hFE000EE3, mk(OP_BEQ, 5'd29, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b0, 32'h108));
    send(32'h123452B7, mk(OP_LUI, 5'd5, 5'd8, 5'd3, 32'h12345000, 1'b1, 32'h10C));
    send(32'h0020A423, mk(OP_SW, 5'd8, 5'd1, 5'd2, 32'h8, 1'b0, 32'h110));
    send(32'hFF9FF0EF, mk(OP_JAL, 5'd1, 5'd31, 5'd25, 32'hFFFFFFF8, 1'b1, 32'h114));
    send(32'h40325213, mk(OP_SRAI, 5'd4, 5'd4, 5'd3, 32'h403, 1'b1, 32'h118));
    send(32'h40208033, mk(OP_SUB, 5'd0, 5'd1, 5'd2, 32'h0, 1'b0, 32'h11C));
    begin
      exp_t f;
      f = mk_ill(32'h120); f.op = OP_NOP; f.ill = 1'b0;
      send(32'h0FF0000F, f);
    end
    send(32'h00000000, mk_ill(32'h124));
    send(32'hFFFFFFFF, mk_ill(32'h128));
    send(32'h02321213, mk_ill(32'h12C));
`ifdef RV32M_DECODE_EN
    div_e = mk(OP_DIV, 5'd10, 5'd11, 5'd12, 32'h0, 1'b1, 32'h130);
`else
    div_e = mk_ill(32'h130);
`endif
    send(32'h02C5C533, div_e);
    repeat (3) @(posedge clk); #1;

    // Back-pressure: two accepts fill main and skid, then in_ready drops
    out_ready = 1'b0;
    send(32'h002081B3, mk(OP_ADD, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1, 32'h200));
    send(32'h123452B7, mk(OP_LUI, 5'd5, 5'd8, 5'd3, 32'h12345000, 1'b1, 32'h204));
    @(negedge clk);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("bp_out_valid",    {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1 out_ready = 1'b1;
    send(32'h0020A423, mk(OP_SW, 5'd8, 5'd1, 5'd2, 32'h8, 1'b0, 32'h208));
    send(32'hFF9FF0EF, mk(OP_JAL, 5'd1, 5'd31, 5'd25, 32'hFFFFFFF8, 1'b1, 32'h20C));
    repeat (4) @(posedge clk); #1;

    // Flush while the skid is full; the offered input in that cycle is dropped
    out_ready = 1'b0;
    send(32'h002081B3, mk(OP_ADD, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1, 32'h300));
    send(32'h123452B7, mk(OP_LUI, 5'd5, 5'd8, 5'd3, 32'h12345000, 1'b1, 32'h304));
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h0020A423; in_pc = 32'h308;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_in_ready",  {31'd0, in_ready},  32'd1);
    out_ready = 1'b1;
    send(32'hFFF00093, mk(OP_ADDI, 5'd1, 5'd0, 5'd31, 32'hFFFFFFFF, 1'b1, 32'h30C));
    check("post_flush_latency", {31'd0, out_valid}, 32'd1);
    repeat (2) @(posedge clk); #1;

    // Flush with in_ready high: the handshake in the flush cycle is discarded
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h400;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_discard", {31'd0, out_valid}, 32'd0);
    repeat (2) @(posedge clk); #1;

    // Asynchronous reset in mid-cycle drops in-flight entries at once
    out_ready = 1'b0;
    send(32'h002081B3, mk(OP_ADD, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1, 32'h500));
    send(32'h40208033, mk(OP_SUB, 5'd0, 5'd1, 5'd2, 32'h0, 1'b0, 32'h504));
    #3 rst_n = 1'b0;
    #1;
    sb.delete();
    check("areset_out_valid", {31'd0, out_valid}, 32'd0);
    check("areset_in_ready",  {31'd0, in_ready},  32'd1);
    @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
    send(32'hFE000EE3, mk(OP_BEQ, 5'd29, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b0, 32'h600));

    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    repeat (2) @(posedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
